// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned XLEN    = 32;

    localparam logic [XLEN-1:0]    PC_INCR   = 32'd4;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return {pc[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO holding {pc, instr} pairs; flush discards everything and wins over push.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned PW    = $clog2(DEPTH),
    localparam int unsigned CW    = PW + 1
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         push_i,
    input  fetch_entry_t push_data_i,
    input  logic         pop_i,
    input  logic         flush_i,
    output fetch_entry_t head_o,
    output logic [CW-1:0] count_o,
    output logic         empty_o,
    output logic         full_o
);

    fetch_entry_t    mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            do_push, do_pop;

    assign do_push = push_i && !flush_i;
    assign do_pop  = pop_i && !flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

    // Push into a full FIFO is legal only when the head leaves in the same cycle.
    always_ff @(posedge clk_i) begin
        if (rst_n_i && !flush_i) begin
            assert (!(push_i && full_o && !pop_i));
            assert (!(pop_i && empty_o));
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the fetch PC, tracks the one in-flight memory read,
// and queues returned words for decode; redirect flushes queued and in-flight work.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned     FIFO_DEPTH = 4
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    output logic [XLEN-1:0]    im_addr_o,
    input  logic [INSTR_W-1:0] im_dout_i,
    input  logic               redirect_i,
    input  logic [XLEN-1:0]    redirect_pc_i,
    output logic               instr_valid_o,
    input  logic               instr_ready_i,
    output logic [INSTR_W-1:0] instr_o,
    output logic [XLEN-1:0]    instr_pc_o
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned OW = CW + 1;

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;
    logic            inflight_q, inflight_d;
    logic [CW-1:0]   count;
    logic [OW-1:0]   occupancy;
    logic            issue, push, pop, empty, full;
    fetch_entry_t    push_entry, head;

    // Counting the in-flight read as occupied reserves a slot, so a push never hits a full FIFO.
    always_comb begin
        occupancy     = {1'b0, count} + OW'(inflight_q);
        issue         = !redirect_i && (occupancy < OW'(FIFO_DEPTH));
        push          = inflight_q && !redirect_i;
        fetch_pc_d    = fetch_pc_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        if (redirect_i) begin
            fetch_pc_d = align_pc(redirect_pc_i);
        end else if (issue) begin
            inflight_d    = 1'b1;
            inflight_pc_d = fetch_pc_q;
            fetch_pc_d    = fetch_pc_q + PC_INCR;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_n_i) assert (!(push && full && !pop));
    end

    assign push_entry = '{pc: inflight_pc_q, instr: im_dout_i};
    assign pop        = instr_valid_o && instr_ready_i;

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .push_i      (push),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .flush_i     (redirect_i),
        .head_o      (head),
        .count_o     (count),
        .empty_o     (empty),
        .full_o      (full)
    );

    assign im_addr_o     = fetch_pc_q;
    assign instr_valid_o = !empty;
    assign instr_o       = instr_valid_o ? head.instr : '0;
    assign instr_pc_o    = instr_valid_o ? head.pc : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: cycle tables for the directed timelines, plus a rule-based
// stream model for redirect, wrap-around and randomized traffic.
module tb_fetch_unit;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic [31:0] im_addr_o;
    logic [31:0] im_dout_i = '0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        instr_valid_o;
    logic        instr_ready_i = 1'b0;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;

    fetch_unit #(
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (4)
    ) dut (
        .clk_i         (clk_i),
        .rst_n_i       (rst_n_i),
        .im_addr_o     (im_addr_o),
        .im_dout_i     (im_dout_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .instr_valid_o (instr_valid_o),
        .instr_ready_i (instr_ready_i),
        .instr_o       (instr_o),
        .instr_pc_o    (instr_pc_o)
    );

    always #5 clk_i = ~clk_i;

    // Instruction memory: word[i] = 0x1000 + i, one-cycle synchronous read.
    function automatic logic [31:0] memw(input logic [31:0] a);
        return 32'h1000 + {2'b00, a[31:2]};
    endfunction

    always @(posedge clk_i) im_dout_i <= memw(im_addr_o);

    typedef struct {
        logic        ready;
        logic        redir;
        logic [31:0] rpc;
        logic        valid;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] addr;
    } vec_t;

    vec_t tbl2 [14];
    vec_t tbl3 [15];

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_next;
    logic [31:0] redir_target;
    int          since_redir;
    logic        hold_prev;
    logic [31:0] prev_pc, prev_instr;
    logic [31:0] acc_q [$];

    logic        r_rdy, r_rd;
    logic [31:0] r_pc;
    logic [31:0] wexp [4];

    function automatic vec_t mk(input logic rdy, input logic rd, input logic [31:0] rpc,
                                input logic v, input logic [31:0] pc, input logic [31:0] ins,
                                input logic [31:0] addr);
        vec_t r;
        r.ready = rdy; r.redir = rd; r.rpc = rpc;
        r.valid = v; r.pc = pc; r.instr = ins; r.addr = addr;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic reset_dut();
        rst_n_i       = 1'b0;
        instr_ready_i = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = '0;
        @(negedge clk_i);
        @(negedge clk_i);
        rst_n_i = 1'b1;
    endtask

    task automatic model_reset();
        exp_next    = 32'h0;
        since_redir = 0;
        hold_prev   = 1'b0;
        acc_q.delete();
    endtask

    task automatic run_row(input vec_t v, input int c, input string tag);
        instr_ready_i = v.ready;
        redirect_i    = v.redir;
        redirect_pc_i = v.rpc;
        chk($sformatf("%s_c%0d_valid", tag, c), 32'(instr_valid_o), 32'(v.valid));
        chk($sformatf("%s_c%0d_addr", tag, c), im_addr_o, v.addr);
        if (v.valid || c == 0) begin
            chk($sformatf("%s_c%0d_pc", tag, c), instr_pc_o, v.pc);
            chk($sformatf("%s_c%0d_instr", tag, c), instr_o, v.instr);
        end
        @(negedge clk_i);
    endtask

    // Stream model: accepted PCs run consecutively from the last redirect target,
    // redirect gives two empty cycles then the target, and a stalled head holds still.
    task automatic mon_cycle(input logic rdy, input logic rd, input logic [31:0] rpc);
        instr_ready_i = rdy;
        redirect_i    = rd;
        redirect_pc_i = rpc;
        if (since_redir == 1) begin
            chk("redir_addr", im_addr_o, redir_target);
            chk("redir_gap1", 32'(instr_valid_o), 32'd0);
        end
        if (since_redir == 2) chk("redir_gap2", 32'(instr_valid_o), 32'd0);
        if (since_redir == 3) chk("redir_valid", 32'(instr_valid_o), 32'd1);
        if (hold_prev) begin
            chk("hold_valid", 32'(instr_valid_o), 32'd1);
            chk("hold_pc", instr_pc_o, prev_pc);
            chk("hold_instr", instr_o, prev_instr);
        end
        if (instr_valid_o && rdy) begin
            chk("acc_pc", instr_pc_o, exp_next);
            chk("acc_instr", instr_o, memw(instr_pc_o));
            acc_q.push_back(instr_pc_o);
            exp_next = exp_next + 32'd4;
        end
        hold_prev  = instr_valid_o && !rdy && !rd;
        prev_pc    = instr_pc_o;
        prev_instr = instr_o;
        if (rd) begin
            redir_target = {rpc[31:2], 2'b00};
            exp_next     = redir_target;
            since_redir  = 1;
        end else if (since_redir != 0 && since_redir < 4) begin
            since_redir++;
        end
        @(negedge clk_i);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Startup, then stall from cycle 3 until the FIFO fills, then drain.
        tbl2[0]  = mk(1, 0, 0, 0, 32'h00, 32'h0000, 32'h00);
        tbl2[1]  = mk(1, 0, 0, 0, 32'h00, 32'h0000, 32'h04);
        tbl2[2]  = mk(1, 0, 0, 1, 32'h00, 32'h1000, 32'h08);
        tbl2[3]  = mk(0, 0, 0, 1, 32'h04, 32'h1001, 32'h0C);
        tbl2[4]  = mk(0, 0, 0, 1, 32'h04, 32'h1001, 32'h10);
        tbl2[5]  = mk(0, 0, 0, 1, 32'h04, 32'h1001, 32'h14);
        tbl2[6]  = mk(0, 0, 0, 1, 32'h04, 32'h1001, 32'h14);
        tbl2[7]  = mk(0, 0, 0, 1, 32'h04, 32'h1001, 32'h14);
        tbl2[8]  = mk(1, 0, 0, 1, 32'h04, 32'h1001, 32'h14);
        tbl2[9]  = mk(1, 0, 0, 1, 32'h08, 32'h1002, 32'h14);
        tbl2[10] = mk(1, 0, 0, 1, 32'h0C, 32'h1003, 32'h18);
        tbl2[11] = mk(1, 0, 0, 1, 32'h10, 32'h1004, 32'h1C);
        tbl2[12] = mk(1, 0, 0, 1, 32'h14, 32'h1005, 32'h20);
        tbl2[13] = mk(1, 0, 0, 1, 32'h18, 32'h1006, 32'h24);
        // Full-rate stream, redirect to 0x203 in cycle 10 while a handshake completes.
        for (int c = 0; c <= 10; c++) begin
            if (c >= 2)
                tbl3[c] = mk(1, c == 10, 32'h203, 1, 32'(4 * (c - 2)), 32'h1000 + 32'(c - 2), 32'(4 * c));
            else
                tbl3[c] = mk(1, 0, 32'h203, 0, 32'h0, 32'h0, 32'(4 * c));
        end
        tbl3[11] = mk(1, 0, 0, 0, 32'h000, 32'h0000, 32'h200);
        tbl3[12] = mk(1, 0, 0, 0, 32'h000, 32'h0000, 32'h204);
        tbl3[13] = mk(1, 0, 0, 1, 32'h200, 32'h1080, 32'h208);
        tbl3[14] = mk(1, 0, 0, 1, 32'h204, 32'h1081, 32'h20C);

        reset_dut();
        for (int c = 0; c < 14; c++) run_row(tbl2[c], c, "fill");

        reset_dut();
        for (int c = 0; c < 15; c++) run_row(tbl3[c], c, "redir");

        // Redirect coinciding with an accepted handshake.
        reset_dut();
        model_reset();
        for (int c = 0; c < 16; c++) mon_cycle(1'b1, c == 5, 32'h400);
        chk("hs_redir_count", 32'(acc_q.size()), 32'd12);
        for (int i = 0; i < 12; i++)
            chk($sformatf("hs_redir_pc%0d", i),
                (i < acc_q.size()) ? acc_q[i] : 32'hDEAD_BEEF,
                (i < 4) ? 32'(4 * i) : 32'h400 + 32'(4 * (i - 4)));

        // PC wrap-around past the top of the address space.
        reset_dut();
        model_reset();
        for (int c = 0; c < 3; c++) mon_cycle(1'b1, 1'b0, 32'h0);
        mon_cycle(1'b1, 1'b1, 32'hFFFF_FFF8);
        acc_q.delete();
        for (int c = 0; c < 20 && acc_q.size() < 4; c++) mon_cycle(1'b1, 1'b0, 32'h0);
        wexp = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
        for (int i = 0; i < 4; i++)
            chk($sformatf("wrap_pc%0d", i), (i < acc_q.size()) ? acc_q[i] : 32'hDEAD_BEEF, wexp[i]);

        // Asynchronous reset with three entries queued, then the startup timeline again.
        reset_dut();
        for (int c = 0; c < 5; c++) run_row(tbl2[c], c, "pre_rst");
        instr_ready_i = 1'b0;
        chk("pre_rst_valid", 32'(instr_valid_o), 32'd1);
        #2 rst_n_i = 1'b0;
        #1;
        chk("async_rst_valid", 32'(instr_valid_o), 32'd0);
        chk("async_rst_addr", im_addr_o, 32'h0);
        chk("async_rst_pc", instr_pc_o, 32'h0);
        chk("async_rst_instr", instr_o, 32'h0);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        for (int c = 0; c < 14; c++) run_row(tbl2[c], c, "post_rst");

        // Randomized ready/redirect traffic against the stream model.
        reset_dut();
        model_reset();
        for (int i = 0; i < 1500; i++) begin
            r_rdy = ($urandom_range(0, 9) < 7);
            r_rd  = ($urandom_range(0, 29) == 0);
            r_pc  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15)) : $urandom();
            mon_cycle(r_rdy, r_rd, r_pc);
        end
        chk("rand_progress", 32'(acc_q.size() > 300), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
